axi4lite_sram_model: RTL

AXI4LITE_SRAM_MODEL -- requirements
Module: axi4lite_sram_model

---
 rtl/axi4lite_sram_pkg.sv | 22 ++
 rtl/axi4lite_sram_rd_queue.sv | 55 +++++
 rtl/axi4lite_sram_model.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/axi4lite_sram_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM model.
package axi4lite_sram_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        LAT_FIXED  = 1'b0,
        LAT_RANDOM = 1'b1
    } lat_mode_t;

    localparam int unsigned LFSR_W    = 16;
    // Fibonacci taps 16,14,13,11 (bit positions 15,13,12,10)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axi4lite_sram_rd_queue.sv
// In-order synchronous FIFO holding pending read responses.
module axi4lite_sram_rd_queue #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == LVL_W'(DEPTH));
    assign empty     = (count == '0);
    assign level     = count;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = store[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axi4lite_sram_model.sv
// AXI4-Lite slave backed by a word-addressed SRAM with fixed or LFSR-driven
// response latency and an in-order queue of outstanding reads.
module axi4lite_sram_model
    import axi4lite_sram_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 32768,
    parameter int unsigned LAT_MODE    = 0,
    parameter int unsigned FIXED_LAT   = 0,
    parameter int unsigned RD_Q        = 4,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    output logic                rvalid,
    input  logic                rready,
    output logic [1:0]          rresp,
    output logic [DATA_W-1:0]   rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFFS   = $clog2(STRB_W);
    localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned ENT_W  = DATA_W + 2;
    localparam int unsigned LVL_W  = $clog2(RD_Q + 1);
    localparam lat_mode_t   MODE   = lat_mode_t'(LAT_MODE[0]);
    localparam logic [3:0]  FIX4   = 4'(FIXED_LAT);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic              aw_held, w_held, b_pend;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    resp_t             b_resp_q;
    logic [3:0]        b_cnt, head_cnt;
    logic [15:0]       lfsr;

    logic              b_hs, b_busy, aw_hs, w_hs, commit;
    logic [ADDR_W-1:0] wr_addr, wr_idx, rd_idx;
    logic [DATA_W-1:0] wr_data, rd_word;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_in_range, rd_in_range;
    resp_t             wr_resp, rd_resp;
    logic [3:0]        lat_load;

    logic              q_push, q_pop, q_full, q_empty, head_load;
    logic [ENT_W-1:0]  q_head;
    logic [LVL_W-1:0]  q_level;

    assign lat_load = (MODE == LAT_RANDOM) ? lfsr[3:0] : FIX4;

    // Write channel: a B handshake frees AW/W acceptance in the same cycle
    assign b_hs    = bvalid && bready;
    assign b_busy  = b_pend && !b_hs;
    assign awready = !aw_held && !b_busy;
    assign wready  = !w_held && !b_busy;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign commit  = aresetn && (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_addr     = aw_held ? aw_addr_q : awaddr;
    assign wr_data     = w_held ? w_data_q : wdata;
    assign wr_strb     = w_held ? w_strb_q : wstrb;
    assign wr_idx      = wr_addr >> OFFS;
    assign wr_in_range = (wr_idx < ADDR_W'(DEPTH_WORDS));
    assign wr_resp     = wr_in_range ? OKAY : SLVERR;

    assign bvalid = b_pend && (b_cnt == 4'd0);
    assign bresp  = b_resp_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            b_pend   <= 1'b0;
            b_resp_q <= OKAY;
            b_cnt    <= 4'd0;
            lfsr     <= SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                b_pend   <= 1'b1;
                b_resp_q <= wr_resp;
                b_cnt    <= lat_load;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
                if (b_hs)  b_pend  <= 1'b0;
                if (b_cnt != 4'd0) b_cnt <= b_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (aw_hs) aw_addr_q <= awaddr;
        if (w_hs) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
        end
    end

    // Memory contents survive reset
    always_ff @(posedge aclk) begin
        if (commit && wr_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) mem[MEM_AW'(wr_idx)][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Read snapshot is taken before this cycle's write lands
    assign rd_idx      = araddr >> OFFS;
    assign rd_in_range = (rd_idx < ADDR_W'(DEPTH_WORDS));
    assign rd_word     = rd_in_range ? mem[MEM_AW'(rd_idx)] : '0;
    assign rd_resp     = rd_in_range ? OKAY : SLVERR;

    assign arready   = !q_full;
    assign q_push    = arvalid && arready;
    assign rvalid    = !q_empty && (head_cnt == 4'd0);
    assign q_pop     = rvalid && rready;
    assign head_load = (q_push && q_empty) || (q_pop && ((q_level > LVL_W'(1)) || q_push));
    assign rdata     = q_head[ENT_W-1:2];
    assign rresp     = q_head[1:0];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            head_cnt <= 4'd0;
        end else if (head_load) begin
            head_cnt <= lat_load;
        end else if (head_cnt != 4'd0) begin
            head_cnt <= head_cnt - 4'd1;
        end
    end

    axi4lite_sram_rd_queue #(
        .WIDTH (ENT_W),
        .DEPTH (RD_Q)
    ) u_rd_queue (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (q_push),
        .push_data ({rd_word, rd_resp}),
        .pop       (q_pop),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .level     (q_level)
    );

endmodule
